// File: rtl/mem_port_arbiter.sv
// Merges instruction fetch and load/store traffic onto the memory's single read and write ports.
// Load/store has priority; a starvation counter forces a fetch grant after STARVE_LIMIT back-to-back ls grants.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ready,
    output logic        fetch_rvalid,
    output logic [31:0] fetch_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_funct3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ready,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_done,
    output logic        ls_misaligned,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_addr,
    input  logic [31:0] mem_read_data
);

    localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        RD_RESP,
        WR
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [CW-1:0] starve_cnt;
    logic          src_ls_q;
    logic          misal_q;
    logic [2:0]    funct3_q;
    logic [31:0]   rd_addr_q;
    logic [31:0]   wr_addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   fetch_rdata_q;
    logic [31:0]   ls_rdata_q;

    logic          fetch_starved;
    logic          grant_ls;
    logic          grant_fetch;
    logic          ls_misal_req;

    // Arbitration is combinational so the ready outputs can answer in the same IDLE cycle.
    always_comb begin
        fetch_starved = fetch_req && (starve_cnt == LIMIT_C);
        grant_ls      = (state == IDLE) && !reset && ls_req && !fetch_starved;
        grant_fetch   = (state == IDLE) && !reset && fetch_req && !grant_ls;
        case (ls_funct3[1:0])
            2'b00:   ls_misal_req = 1'b0;
            2'b01:   ls_misal_req = ls_addr[0];
            default: ls_misal_req = (ls_addr[1:0] != 2'b00);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_ls) begin
                    if (ls_misal_req) begin
                        state_nxt = IDLE;
                    end else if (ls_we) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD_ISSUE;
                    end
                end else if (grant_fetch) begin
                    state_nxt = RD_ISSUE;
                end
            end
            RD_ISSUE: state_nxt = RD_RESP;
            RD_RESP:  state_nxt = IDLE;
            WR:       state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fetch_ready    = grant_fetch;
        ls_ready       = grant_ls;
        fetch_rvalid   = (state == RD_RESP) && !src_ls_q;
        ls_rvalid      = (state == RD_RESP) && src_ls_q;
        ls_done        = (state == WR) || misal_q;
        ls_misaligned  = misal_q;
        mem_write      = (state == WR);
        fetch_rdata    = fetch_rdata_q;
        ls_rdata       = ls_rdata_q;
        mem_funct3     = funct3_q;
        mem_write_addr = wr_addr_q;
        mem_write_data = wdata_q;
        mem_read_addr  = rd_addr_q;
    end

    // Counter only moves in IDLE, so it survives the multi-cycle transactions between grants.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_ls && fetch_req) begin
                if (starve_cnt != LIMIT_C) begin
                    starve_cnt <= starve_cnt + CW'(1);
                end
            end else if (grant_fetch || !fetch_req) begin
                starve_cnt <= '0;
            end
        end
    end

    // Separate read/write address registers keep mem_read_addr stable across stores.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_ls_q  <= 1'b0;
            misal_q   <= 1'b0;
            funct3_q  <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wdata_q   <= '0;
        end else begin
            misal_q <= grant_ls && ls_misal_req;
            if (grant_fetch) begin
                src_ls_q  <= 1'b0;
                funct3_q  <= 3'b010;
                rd_addr_q <= fetch_addr;
            end else if (grant_ls && !ls_misal_req) begin
                src_ls_q <= 1'b1;
                funct3_q <= ls_funct3;
                if (ls_we) begin
                    wr_addr_q <= ls_addr;
                    wdata_q   <= ls_wdata;
                end else begin
                    rd_addr_q <= ls_addr;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_rdata_q <= '0;
            ls_rdata_q    <= '0;
        end else if (state == RD_ISSUE) begin
            if (src_ls_q) begin
                ls_rdata_q <= mem_read_data;
            end else begin
                fetch_rdata_q <= mem_read_data;
            end
        end
    end

endmodule
